// File: rtl/my_fetch.sv
// Instruction fetch controller: drives the PC register load, handshakes with
// instruction memory, and holds each fetched instruction for decode.
module my_fetch #(
    parameter logic [31:0] EXC_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_t;

    state_t state;
    logic   take_exc;
    logic   take_redir;
    logic   fetch_done;

    // Everything is gated by rst so nothing leaks out while reset is held.
    always_comb begin
        take_exc   = rst && exc_valid;
        take_redir = rst && redirect_valid;
        fetch_done = rst && (state == StFetch) && imem_ready;
        imem_req   = rst && (state == StFetch);
        pc_ena     = take_exc || take_redir || fetch_done;
        pc_next    = pc_cur;
        if (take_exc) begin
            pc_next = EXC_VEC;
        end else if (take_redir) begin
            pc_next = {redirect_target[31:2], 2'b00};
        end else if (fetch_done) begin
            pc_next = pc_cur + 32'd4;
        end
    end

    assign imem_addr = pc_cur;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= StIdle;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
        end else if (exc_valid || redirect_valid) begin
            // Any returning memory data is wrong-path and is dropped here.
            inst_valid <= 1'b0;
            state      <= StFetch;
        end else begin
            unique case (state)
                StIdle: begin
                    state <= StFetch;
                end
                StFetch: begin
                    if (imem_ready) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc_cur;
                        inst_valid <= 1'b1;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= StFetch;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_fetch.sv
// Randomised and directed bench for my_fetch, checked against a behavioural
// model of the fetch/present/redirect rules and a PC register kept here.
module tb_my_fetch;

    localparam logic [31:0] EXC = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;

    // Model: waiting out the post-reset cycle, requesting, or presenting.
    bit          m_idle = 1'b1;
    bit          m_req = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_inst_pc = 32'h0;
    logic        e_req;
    logic        e_ena;
    logic [31:0] e_next;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    my_fetch #(.EXC_VEC(EXC)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .pc_ena          (pc_ena),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid)
    );

    // Apply inputs just after an edge, predict the combinational outputs, then
    // settle to mid-cycle where the calling test samples.
    task automatic drive(input logic r, input logic rdy, input logic [31:0] rd,
                         input logic irdy, input logic rv, input logic [31:0] tg,
                         input logic ev);
        rst = r; imem_ready = rdy; imem_rdata = rd; inst_ready = irdy;
        redirect_valid = rv; redirect_target = tg; exc_valid = ev;
        e_req = r && m_req;
        e_ena = r && (ev || rv || (m_req && rdy));
        if (!e_ena)   e_next = pc_cur;
        else if (ev)  e_next = EXC;
        else if (rv)  e_next = (tg / 4) * 4;
        else          e_next = pc_cur + 32'd4;
        #3;
    endtask

    // Clock edge: advance the model and the PC register.
    task automatic step();
        logic        ena;
        logic [31:0] nxt;
        ena = pc_ena;
        nxt = pc_next;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_idle = 1; m_req = 0; m_valid = 0; m_inst = 0; m_inst_pc = 0;
        end else if (exc_valid || redirect_valid) begin
            m_idle = 0; m_req = 1; m_valid = 0;
        end else if (m_idle) begin
            m_idle = 0; m_req = 1;
        end else if (m_req && imem_ready) begin
            m_req = 0; m_valid = 1; m_inst = imem_rdata; m_inst_pc = pc_cur;
        end else if (m_valid && inst_ready) begin
            m_valid = 0; m_req = 1;
        end
        if (ena) pc_cur = nxt;
    endtask

    // Reset, load the PC register, then burn the idle cycle so FETCH is next.
    task automatic reset_to_fetch(input logic [31:0] pc);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        pc_cur = pc;
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom));
            n_checks++;
            if ({imem_req, pc_ena, pc_next, imem_addr} !== {2'b00, pc_cur, pc_cur})
                $display("FAIL reset_comb: req/ena/next/addr %b/%b/%h/%h want 0/0/%h/%h",
                         imem_req, pc_ena, pc_next, imem_addr, pc_cur, pc_cur);
            else n_pass++;
            step();
            n_checks++;
            if ({inst_valid, inst, inst_pc} !== 65'h0)
                $display("FAIL reset_regs: valid/inst/pc %b/%h/%h want 0/0/0",
                         inst_valid, inst, inst_pc);
            else n_pass++;
        end
    endtask

    task automatic test_sequential();
        pc_cur = 32'h0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, $urandom, 1, 0, $urandom, 0);
            n_checks++;
            if ({imem_req, pc_ena, pc_next} !== {e_req, e_ena, e_next})
                $display("FAIL seq_comb cyc %0d: req/ena/next %b/%b/%h want %b/%b/%h", i,
                         imem_req, pc_ena, pc_next, e_req, e_ena, e_next);
            else n_pass++;
            step();
            n_checks++;
            if (inst_valid !== 1'(i % 2) || (i % 2 == 1 && inst_pc !== 32'(4 * (i / 2))))
                $display("FAIL seq_inst cyc %0d: valid/pc %b/%h want %b/%h", i, inst_valid,
                         inst_pc, 1'(i % 2), 32'(4 * (i / 2)));
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        reset_to_fetch(32'h40);
        for (int k = 0; k < 4; k++) begin
            drive(1, k == 3, 32'hCAFE_0000 + 32'(k), 0, 0, 0, 0);
            n_checks++;
            if (imem_req !== 1'b1 || pc_ena !== (k == 3))
                $display("FAIL wait_req k=%0d: req/ena %b/%b want 1/%b", k, imem_req,
                         pc_ena, k == 3);
            else n_pass++;
            step();
            n_checks++;
            if (inst_valid !== (k == 3))
                $display("FAIL wait_valid edge %0d: got %b want %b", k + 1, inst_valid,
                         k == 3);
            else n_pass++;
        end
        n_checks++;
        if ({inst, inst_pc} !== {32'hCAFE_0003, 32'h40})
            $display("FAIL wait_data: inst/pc %h/%h want cafe0003/00000040", inst, inst_pc);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] word;
        word = $urandom;
        reset_to_fetch(32'h80);
        drive(1, 1, word, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'($urandom), $urandom, 0, 0, $urandom, 0);
            n_checks++;
            if (imem_req !== 1'b0 || pc_ena !== 1'b0)
                $display("FAIL bp_comb cyc %0d: req/ena %b/%b want 0/0", i, imem_req, pc_ena);
            else n_pass++;
            step();
            n_checks++;
            if ({inst_valid, inst, inst_pc} !== {1'b1, word, 32'h80})
                $display("FAIL bp_hold cyc %0d: valid/inst/pc %b/%h/%h want 1/%h/00000080",
                         i, inst_valid, inst, inst_pc, word);
            else n_pass++;
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        step();
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL bp_release: valid/req %b/%b want 0/1", inst_valid, imem_req);
        else n_pass++;
    endtask

    task automatic test_redirect_priority();
        reset_to_fetch(32'h300);
        drive(1, 0, 0, 0, 1, 32'h100, 1);
        n_checks++;
        if (pc_ena !== 1'b1 || pc_next !== 32'h4)
            $display("FAIL prio_next: ena/next %b/%h want 1/00000004", pc_ena, pc_next);
        else n_pass++;
        step();
        drive(1, 1, $urandom, 0, 0, 0, 0);
        step();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4)
            $display("FAIL prio_inst_pc: valid/pc %b/%h want 1/00000004", inst_valid, inst_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_fetch();
        reset_to_fetch(32'h500);
        drive(1, 1, 32'hDEAD_BEEF, 0, 1, 32'h203, 0);
        n_checks++;
        if (pc_ena !== 1'b1 || pc_next !== 32'h200)
            $display("FAIL redir_next: ena/next %b/%h want 1/00000200", pc_ena, pc_next);
        else n_pass++;
        step();
        n_checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h200)
            $display("FAIL redir_discard: valid/addr %b/%h want 0/00000200", inst_valid,
                     imem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        reset_to_fetch(32'hFFFF_FFFC);
        drive(1, 1, $urandom | 32'h1, 0, 0, 0, 0);
        n_checks++;
        if (pc_ena !== 1'b1 || pc_next !== 32'h0)
            $display("FAIL wrap_next: ena/next %b/%h want 1/00000000", pc_ena, pc_next);
        else n_pass++;
        step();
        drive(0, 1, $urandom, 1'($urandom), 1, $urandom, 1);
        n_checks++;
        if (pc_ena !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL midrst_comb: ena/req %b/%b want 0/0", pc_ena, imem_req);
        else n_pass++;
        step();
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== 65'h0)
            $display("FAIL midrst_regs: valid/inst/pc %b/%h/%h want 0/0/0", inst_valid, inst,
                     inst_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) != 0);
            drive(r, 1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom, $urandom_range(0, 15) == 0);
            n_checks++;
            if ({imem_req, pc_ena, pc_next, imem_addr} !== {e_req, e_ena, e_next, pc_cur})
                $display("FAIL rand_comb cyc %0d: req/ena/next %b/%b/%h want %b/%b/%h", i,
                         imem_req, pc_ena, pc_next, e_req, e_ena, e_next);
            else n_pass++;
            step();
            n_checks++;
            if (inst_valid !== m_valid ||
                ((m_valid || !rst) && {inst, inst_pc} !== {m_inst, m_inst_pc}))
                $display("FAIL rand_regs cyc %0d: valid/inst/pc %b/%h/%h want %b/%h/%h", i,
                         inst_valid, inst, inst_pc, m_valid, m_inst, m_inst_pc);
            else n_pass++;
        end
    endtask

    initial begin
        pc_cur = 32'h0;
        rst = 0; imem_ready = 0; imem_rdata = 0; inst_ready = 0;
        redirect_valid = 0; redirect_target = 0; exc_valid = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_wait_states();
        test_backpressure();
        test_redirect_priority();
        test_redirect_fetch();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
